// File: rtl/ipml_fifo_wr_packer.sv
// rtl/ipml_fifo_wr_packer.sv - packs narrow input beats into wide FIFO words with per-lane keep
module ipml_fifo_wr_packer #(
  parameter int c_IN_DATA_WIDTH = 8,
  parameter int c_RATIO         = 4,
  parameter int c_CNT_WIDTH     = 16
) (
  input  logic                                 wr_clk,
  input  logic                                 wr_rst,
  input  logic [c_IN_DATA_WIDTH-1:0]           in_data,
  input  logic                                 in_valid,
  input  logic                                 in_last,
  output logic                                 in_ready,
  output logic [c_IN_DATA_WIDTH*c_RATIO-1:0]   fifo_wr_data,
  output logic [c_RATIO-1:0]                   fifo_wr_keep,
  output logic                                 fifo_wr_en,
  input  logic                                 fifo_wr_vld,
  output logic                                 busy,
  output logic [c_CNT_WIDTH-1:0]               word_cnt
);

  localparam int c_W      = c_IN_DATA_WIDTH;
  localparam int c_WORD_W = c_IN_DATA_WIDTH * c_RATIO;
  localparam int c_LANE_W = $clog2(c_RATIO);
  localparam logic [c_LANE_W-1:0] c_LAST_LANE = c_LANE_W'(c_RATIO - 1);

  logic [c_LANE_W-1:0]    lane_cnt_q, lane_cnt_d;
  logic [c_WORD_W-1:0]    acc_data_q, acc_data_d;
  logic [c_RATIO-1:0]     acc_keep_q, acc_keep_d;
  logic [c_WORD_W-1:0]    out_data_q, out_data_d;
  logic [c_RATIO-1:0]     out_keep_q, out_keep_d;
  logic                   out_valid_q, out_valid_d;
  logic [c_CNT_WIDTH-1:0] word_cnt_q, word_cnt_d;

  logic [c_WORD_W-1:0]    merged_data;
  logic [c_RATIO-1:0]     merged_keep;
  logic                   beat_acc;
  logic                   beat_done;
  logic                   wr_fire;

  // The single output slot can take a new word whenever it is empty or is being drained this cycle.
  assign in_ready  = ~out_valid_q | fifo_wr_vld;
  assign beat_acc  = in_valid & in_ready;
  assign beat_done = beat_acc & ((lane_cnt_q == c_LAST_LANE) | in_last);
  assign wr_fire   = out_valid_q & fifo_wr_vld;

  // Accumulator contents with the current beat dropped into its lane.
  always_comb begin
    merged_data = acc_data_q;
    merged_keep = acc_keep_q;
    for (int i = 0; i < c_RATIO; i++) begin
      if (lane_cnt_q == c_LANE_W'(i)) begin
        merged_data[i*c_W +: c_W] = in_data;
        merged_keep[i]            = 1'b1;
      end
    end
  end

  // Next-state for accumulator, output slot and word counter.
  always_comb begin
    lane_cnt_d  = lane_cnt_q;
    acc_data_d  = acc_data_q;
    acc_keep_d  = acc_keep_q;
    out_data_d  = out_data_q;
    out_keep_d  = out_keep_q;
    out_valid_d = out_valid_q;
    word_cnt_d  = word_cnt_q;

    if (beat_done) begin
      // Clearing the data as well as keep guarantees unused lanes of the next partial word read as zero.
      lane_cnt_d  = '0;
      acc_data_d  = '0;
      acc_keep_d  = '0;
      out_data_d  = merged_data;
      out_keep_d  = merged_keep;
      out_valid_d = 1'b1;
    end else begin
      if (beat_acc) begin
        lane_cnt_d = lane_cnt_q + c_LANE_W'(1);
        acc_data_d = merged_data;
        acc_keep_d = merged_keep;
      end
      if (wr_fire) begin
        out_valid_d = 1'b0;
      end
    end

    if (wr_fire) begin
      word_cnt_d = word_cnt_q + c_CNT_WIDTH'(1);
    end
  end

  // State registers with synchronous reset discarding any partial or pending word.
  always_ff @(posedge wr_clk) begin
    if (wr_rst) begin
      lane_cnt_q  <= '0;
      acc_data_q  <= '0;
      acc_keep_q  <= '0;
      out_data_q  <= '0;
      out_keep_q  <= '0;
      out_valid_q <= 1'b0;
      word_cnt_q  <= '0;
    end else begin
      lane_cnt_q  <= lane_cnt_d;
      acc_data_q  <= acc_data_d;
      acc_keep_q  <= acc_keep_d;
      out_data_q  <= out_data_d;
      out_keep_q  <= out_keep_d;
      out_valid_q <= out_valid_d;
      word_cnt_q  <= word_cnt_d;
    end
  end

  // Outputs are forced quiet while reset is asserted so a pending pre-reset word never reaches the FIFO.
  assign fifo_wr_en   = wr_fire & ~wr_rst;
  assign fifo_wr_data = wr_rst ? '0 : out_data_q;
  assign fifo_wr_keep = wr_rst ? '0 : out_keep_q;
  assign busy         = ~wr_rst & ((lane_cnt_q != '0) | out_valid_q);
  assign word_cnt     = word_cnt_q;

endmodule

// File: tb/tb_ipml_fifo_wr_packer.sv
// tb/tb_ipml_fifo_wr_packer.sv - self-checking bench for ipml_fifo_wr_packer
module tb_ipml_fifo_wr_packer;

  localparam int W = 8;
  localparam int R = 4;

  logic        clk = 1'b0;
  logic        wr_rst;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_last;
  logic        in_ready, in_ready4;
  logic [31:0] fifo_wr_data, fifo_wr_data4;
  logic [3:0]  fifo_wr_keep, fifo_wr_keep4;
  logic        fifo_wr_en, fifo_wr_en4;
  logic        fifo_wr_vld;
  logic        busy, busy4;
  logic [15:0] word_cnt;
  logic [3:0]  word_cnt4;

  int ntests = 0;
  int nfail  = 0;
  bit mon_on = 1'b0;

  always #5 clk = ~clk;

  ipml_fifo_wr_packer #(.c_IN_DATA_WIDTH(W), .c_RATIO(R), .c_CNT_WIDTH(16)) dut (
    .wr_clk(clk), .wr_rst(wr_rst), .in_data(in_data), .in_valid(in_valid), .in_last(in_last),
    .in_ready(in_ready), .fifo_wr_data(fifo_wr_data), .fifo_wr_keep(fifo_wr_keep),
    .fifo_wr_en(fifo_wr_en), .fifo_wr_vld(fifo_wr_vld), .busy(busy), .word_cnt(word_cnt)
  );

  ipml_fifo_wr_packer #(.c_IN_DATA_WIDTH(W), .c_RATIO(R), .c_CNT_WIDTH(4)) dut4 (
    .wr_clk(clk), .wr_rst(wr_rst), .in_data(in_data), .in_valid(in_valid), .in_last(in_last),
    .in_ready(in_ready4), .fifo_wr_data(fifo_wr_data4), .fifo_wr_keep(fifo_wr_keep4),
    .fifo_wr_en(fifo_wr_en4), .fifo_wr_vld(fifo_wr_vld), .busy(busy4), .word_cnt(word_cnt4)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    ntests++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    wr_rst   = 1'b1;
    in_valid = 1'b0;
    in_last  = 1'b0;
    step();
    wr_rst   = 1'b0;
  endtask

  // Reference model: words are lists of accepted beats; a word is owed to the FIFO until written.
  logic [31:0] exp_data_q[$];
  logic [3:0]  exp_keep_q[$];
  int          part_n = 0;
  logic [31:0] part_data = '0;
  logic [15:0] mcnt = '0;

  always @(negedge clk) begin
    bit          pend;
    logic [31:0] shifted;
    logic [3:0]  kp;
    if (mon_on) begin
      pend = (exp_data_q.size() > 0);
      if (wr_rst) begin
        chk("rst_en", fifo_wr_en, 0);
        chk("rst_data", fifo_wr_data, 0);
        chk("rst_keep", fifo_wr_keep, 0);
        chk("rst_busy", busy, 0);
        chk("rst_ready", in_ready, !pend || fifo_wr_vld);
        exp_data_q.delete();
        exp_keep_q.delete();
        part_n    = 0;
        part_data = '0;
        mcnt      = '0;
      end else begin
        chk("m_ready", in_ready, !pend || fifo_wr_vld);
        chk("m_en", fifo_wr_en, pend && fifo_wr_vld);
        chk("m_busy", busy, pend || (part_n != 0));
        chk("m_cnt", word_cnt, mcnt);
        chk("m_cnt4", word_cnt4, mcnt[3:0]);
        if (pend && fifo_wr_vld) begin
          chk("m_data", fifo_wr_data, exp_data_q[0]);
          chk("m_keep", fifo_wr_keep, exp_keep_q[0]);
          void'(exp_data_q.pop_front());
          void'(exp_keep_q.pop_front());
          mcnt = mcnt + 16'd1;
        end
        if (in_valid && (!pend || fifo_wr_vld)) begin
          shifted   = 32'(in_data) << (part_n * W);
          part_data = part_data | shifted;
          part_n++;
          if (part_n == R || in_last) begin
            kp = '0;
            for (int i = 0; i < part_n; i++) kp[i] = 1'b1;
            exp_data_q.push_back(part_data);
            exp_keep_q.push_back(kp);
            part_n    = 0;
            part_data = '0;
          end
        end
      end
    end
  end

  typedef struct {
    logic        v;
    logic [7:0]  d;
    logic        l;
    logic        vld;
    logic        e_en;
    logic        e_ready;
    logic        chkd;
    logic [31:0] e_data;
    logic [3:0]  e_keep;
    logic [15:0] e_cnt;
  } vec_t;

  vec_t tbl[16];

  initial begin
    int          nen, bad, got;
    logic [31:0] cap_d;
    logic [3:0]  cap_k;

    tbl[0]  = '{1, 8'h11, 0, 1, 0, 1, 0, 32'h0,        4'h0, 0};
    tbl[1]  = '{1, 8'h22, 0, 1, 0, 1, 0, 32'h0,        4'h0, 0};
    tbl[2]  = '{1, 8'h33, 0, 1, 0, 1, 0, 32'h0,        4'h0, 0};
    tbl[3]  = '{1, 8'h44, 0, 1, 0, 1, 0, 32'h0,        4'h0, 0};
    tbl[4]  = '{1, 8'hA1, 0, 1, 1, 1, 1, 32'h44332211, 4'hF, 0};
    tbl[5]  = '{1, 8'hA2, 1, 1, 0, 1, 0, 32'h0,        4'h0, 1};
    tbl[6]  = '{1, 8'hB1, 0, 0, 0, 0, 1, 32'h0000A2A1, 4'h3, 1};
    tbl[7]  = '{1, 8'hB1, 0, 1, 1, 1, 1, 32'h0000A2A1, 4'h3, 1};
    tbl[8]  = '{1, 8'hB2, 0, 1, 0, 1, 0, 32'h0,        4'h0, 2};
    tbl[9]  = '{1, 8'hB3, 0, 1, 0, 1, 0, 32'h0,        4'h0, 2};
    tbl[10] = '{1, 8'hB4, 0, 1, 0, 1, 0, 32'h0,        4'h0, 2};
    tbl[11] = '{1, 8'hC1, 0, 0, 0, 0, 1, 32'hB4B3B2B1, 4'hF, 2};
    tbl[12] = '{1, 8'hC1, 0, 0, 0, 0, 1, 32'hB4B3B2B1, 4'hF, 2};
    tbl[13] = '{1, 8'hC1, 0, 1, 1, 1, 1, 32'hB4B3B2B1, 4'hF, 2};
    tbl[14] = '{1, 8'hC2, 1, 1, 0, 1, 0, 32'h0,        4'h0, 3};
    tbl[15] = '{0, 8'h00, 0, 1, 1, 1, 1, 32'h0000C2C1, 4'h3, 3};

    wr_rst      = 1'b1;
    in_data     = '0;
    in_valid    = 1'b0;
    in_last     = 1'b0;
    fifo_wr_vld = 1'b1;
    repeat (2) step();
    mon_on = 1'b1;
    @(negedge clk);
    chk("reset_en", fifo_wr_en, 0);
    chk("reset_data", fifo_wr_data, 0);
    chk("reset_keep", fifo_wr_keep, 0);
    chk("reset_busy", busy, 0);
    chk("reset_ready", in_ready, 1);
    chk("reset_cnt", word_cnt, 0);
    step();
    wr_rst = 1'b0;

    // Cycle-by-cycle vector table
    for (int i = 0; i < 16; i++) begin
      in_valid    = tbl[i].v;
      in_data     = tbl[i].d;
      in_last     = tbl[i].l;
      fifo_wr_vld = tbl[i].vld;
      @(negedge clk);
      chk($sformatf("tbl%0d_en", i), fifo_wr_en, tbl[i].e_en);
      chk($sformatf("tbl%0d_ready", i), in_ready, tbl[i].e_ready);
      chk($sformatf("tbl%0d_cnt", i), word_cnt, tbl[i].e_cnt);
      if (tbl[i].chkd) begin
        chk($sformatf("tbl%0d_data", i), fifo_wr_data, tbl[i].e_data);
        chk($sformatf("tbl%0d_keep", i), fifo_wr_keep, tbl[i].e_keep);
      end
      step();
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    step();

    // in_last on the final lane yields exactly one full word
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1;
      in_data  = 8'hD1 + 8'(i);
      in_last  = (i == 3);
      step();
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    nen = 0;
    cap_k = '0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (fifo_wr_en) begin
        nen++;
        cap_k = fifo_wr_keep;
      end
      step();
    end
    chk("last_full_writes", nen, 1);
    chk("last_full_keep", cap_k, 4'hF);

    // Reset in the middle of a word
    for (int i = 0; i < 2; i++) begin
      in_valid = 1'b1;
      in_data  = 8'h90 + 8'(i);
      step();
    end
    do_reset();
    @(negedge clk);
    chk("midword_rst_busy", busy, 0);
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1;
      in_data  = 8'hE1 + 8'(i);
      step();
    end
    in_valid = 1'b0;
    got = 0;
    cap_d = '0;
    cap_k = '0;
    for (int k = 0; k < 8 && got == 0; k++) begin
      @(negedge clk);
      if (fifo_wr_en) begin
        got = 1;
        cap_d = fifo_wr_data;
        cap_k = fifo_wr_keep;
      end
      step();
    end
    chk("post_rst_word_seen", got, 1);
    chk("post_rst_word_data", cap_d, 32'hE4E3E2E1);
    chk("post_rst_word_keep", cap_k, 4'hF);

    // Eight words streamed back to back
    do_reset();
    nen = 0;
    bad = 0;
    for (int i = 0; i < 36; i++) begin
      in_valid = (i < 32);
      in_data  = 8'(i);
      @(negedge clk);
      if (fifo_wr_en) begin
        nen++;
        if ((i % 4) != 0 || i < 4) bad++;
      end
      if (i < 32 && !in_ready) bad++;
      step();
    end
    @(negedge clk);
    chk("stream_writes", nen, 8);
    chk("stream_gaps", bad, 0);
    chk("stream_cnt", word_cnt, 8);
    step();

    // Narrow counter wraps after 17 words
    do_reset();
    for (int i = 0; i < 68; i++) begin
      in_valid = 1'b1;
      in_data  = 8'($urandom);
      step();
    end
    in_valid = 1'b0;
    repeat (3) step();
    @(negedge clk);
    chk("wrap_cnt4", word_cnt4, 1);
    chk("wrap_cnt16", word_cnt, 17);
    step();

    // Randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      in_valid    = ($urandom_range(0, 3) != 0);
      in_data     = 8'($urandom);
      in_last     = ($urandom_range(0, 4) == 0);
      fifo_wr_vld = ($urandom_range(0, 9) < 7);
      wr_rst      = ($urandom_range(0, 299) == 0);
      step();
    end
    wr_rst      = 1'b0;
    in_valid    = 1'b0;
    in_last     = 1'b0;
    fifo_wr_vld = 1'b1;
    repeat (4) step();
    @(negedge clk);
    chk("drain_busy", busy, part_n != 0);

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
